// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DEFAULT_W = 4;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Last counter value of a 2*half period; the caller sizes it to W+1 bits.
    function automatic int unsigned term_cnt(input int unsigned half);
        return 2 * half - 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and combinational div_out/tick decode from registered state.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         run,
    input  logic [W-1:0] cur_half,
    output logic         at_term,
    output logic         div_out,
    output logic         tick
);

    localparam int unsigned CW = W + 1;

    logic [W:0] cnt;
    logic [W:0] term;

    assign term = CW'(term_cnt(32'(cur_half)));

    always_ff @(posedge clk) begin
        if (!resetn || !run) begin
            cnt <= '0;
        end else if (at_term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Low first cycle after each wrap, then cur_half high cycles.
    always_comb begin
        at_term = run && (cnt == term);
        div_out = run && (cnt != '0) && (cnt <= {1'b0, cur_half});
        tick    = run && (cnt == CW'(1));
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: STOP/RUN/PEND FSM, pending half-period and ready/valid handshake.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned W          = DEFAULT_W,
    parameter int unsigned RESET_HALF = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_half,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] cur_half
);

    localparam logic [W-1:0] RST_HALF  = W'(RESET_HALF);
    localparam state_t       RST_STATE = (RESET_HALF == 0) ? STOP : RUN;

    state_t       state_q, state_d;
    logic [W-1:0] half_q, half_d;
    logic [W-1:0] pending_q, pending_d;
    logic         done_q, done_d;
    logic         at_term;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= RST_STATE;
            half_q    <= RST_HALF;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        cfg_ready = (state_q != PEND);
        unique case (state_q)
            STOP: begin
                if (cfg_valid) begin
                    half_d  = cfg_half;
                    done_d  = 1'b1;
                    state_d = (cfg_half == '0) ? STOP : RUN;
                end
            end
            RUN: begin
                // Acceptance on the terminal cycle still lands in PEND, so it waits a full period.
                if (cfg_valid) begin
                    pending_d = cfg_half;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (at_term) begin
                    half_d  = pending_q;
                    done_d  = 1'b1;
                    state_d = (pending_q == '0) ? STOP : RUN;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    assign cfg_done = done_q;
    assign cur_half = half_q;

    clk_div_core #(
        .W(W)
    ) u_core (
        .clk      (clk),
        .resetn   (resetn),
        .run      (state_q != STOP),
        .cur_half (half_q),
        .at_term  (at_term),
        .div_out  (div_out),
        .tick     (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (RESET_HALF=1 and RESET_HALF=3 instances).
module tb_clk_div_ctrl;

    logic       clk;
    logic       resetn;
    logic       v1, v3;
    logic [3:0] h1, h3;
    logic       rdy1, rdy3, done1, done3, div1, div3, tick1, tick3;
    logic [3:0] cur1, cur3;

    int unsigned n_checks;
    int unsigned n_err;

    clk_div_ctrl #(.W(4), .RESET_HALF(1)) dut1 (
        .clk(clk), .resetn(resetn), .cfg_valid(v1), .cfg_half(h1),
        .cfg_ready(rdy1), .cfg_done(done1), .div_out(div1), .tick(tick1), .cur_half(cur1)
    );

    clk_div_ctrl #(.W(4), .RESET_HALF(3)) dut3 (
        .clk(clk), .resetn(resetn), .cfg_valid(v3), .cfg_half(h3),
        .cfg_ready(rdy3), .cfg_done(done3), .div_out(div3), .tick(tick3), .cur_half(cur3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot of the RESET_HALF=3 instance.
    task automatic chk3(input string tag, input logic div_e, input logic tick_e,
                        input logic rdy_e, input logic done_e, input logic [3:0] cur_e);
        chk({tag, ".div"},  32'(div3),  32'(div_e));
        chk({tag, ".tick"}, 32'(tick3), 32'(tick_e));
        chk({tag, ".rdy"},  32'(rdy3),  32'(rdy_e));
        chk({tag, ".done"}, 32'(done3), 32'(done_e));
        chk({tag, ".cur"},  32'(cur3),  32'(cur_e));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        resetn   = 1'b0;
        v1 = 1'b0; h1 = 4'd0;
        v3 = 1'b0; h3 = 4'd0;

        // Reset values
        cycle();
        chk("rst1.div",  32'(div1),  32'd0);
        chk("rst1.tick", 32'(tick1), 32'd0);
        chk("rst1.done", 32'(done1), 32'd0);
        chk("rst1.rdy",  32'(rdy1),  32'd1);
        chk("rst1.cur",  32'(cur1),  32'd1);
        chk3("rst3", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        resetn = 1'b1;

        // Divide-by-2 after reset: cnt alternates 1,0,...
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("div2.div",  32'(div1),  32'(k % 2));
            chk("div2.tick", 32'(tick1), 32'(k % 2));
            chk("div2.rdy",  32'(rdy1),  32'd1);
            chk("div2.done", 32'(done1), 32'd0);
        end

        // Request half=2 at cnt=1 while running half=3
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();                                   // cnt=1
        chk3("req2.pre", 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        v3 = 1'b1; h3 = 4'd2;
        cycle();                                   // cnt=2, PEND
        v3 = 1'b0;
        chk3("req2.c2", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        cycle();
        chk3("req2.c3", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        cycle();
        chk3("req2.c4", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        cycle();
        chk3("req2.c5", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        cycle();                                   // wrap, applied
        chk3("req2.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        for (int j = 1; j <= 8; j++) begin
            cycle();
            chk3("req2.run", ((j % 4) == 1) || ((j % 4) == 2), (j % 4) == 1, 1'b1, 1'b0, 4'd2);
        end

        // Stop with half=0, then restart with half=1 (starting at cnt=0, half=2)
        v3 = 1'b1; h3 = 4'd0;
        cycle();                                   // cnt=1, PEND
        v3 = 1'b0;
        chk3("stop.c1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        cycle();
        cycle();                                   // cnt=3 terminal
        chk3("stop.c3", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        cycle();
        chk3("stop.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk3("stop.hold", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        end
        v3 = 1'b1; h3 = 4'd1;
        cycle();
        v3 = 1'b0;
        chk3("start.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
        cycle();
        chk3("start.rise", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
        cycle();                                   // cnt=0, half=1

        // Go to half=3, then a second request in PEND must be ignored
        v3 = 1'b1; h3 = 4'd3;
        cycle();                                   // cnt=1 terminal, PEND
        v3 = 1'b0;
        chk3("to3.pend", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        cycle();
        chk3("to3.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
        cycle();                                   // cnt=1
        v3 = 1'b1; h3 = 4'd2;
        cycle();                                   // cnt=2, PEND holding 2
        h3 = 4'd7;
        for (int j = 3; j <= 5; j++) begin
            cycle();
            chk3("ign.pend", j <= 3, 1'b0, 1'b0, 1'b0, 4'd3);
        end
        cycle();
        v3 = 1'b0;
        chk3("ign.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);

        // Request half=5 exactly on the terminal count of half=3
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        for (int j = 1; j <= 5; j++) cycle();      // cnt=5
        chk3("term.pre", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        v3 = 1'b1; h3 = 4'd5;
        cycle();                                   // wrap with old half, PEND
        v3 = 1'b0;
        chk3("term.c0", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        for (int j = 1; j <= 5; j++) begin
            cycle();
            chk3("term.old", j <= 3, j == 1, 1'b0, 1'b0, 4'd3);
        end
        cycle();
        chk3("term.apply", 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        for (int j = 1; j <= 20; j++) begin
            cycle();
            chk3("term.new", ((j % 10) >= 1) && ((j % 10) <= 5), (j % 10) == 1, 1'b1, 1'b0, 4'd5);
        end

        // Reset while PEND discards the request
        v3 = 1'b1; h3 = 4'd2;
        cycle();
        v3 = 1'b0;
        chk("rstp.rdy", 32'(rdy3), 32'd0);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        chk3("rstp.rst", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        for (int j = 1; j <= 12; j++) begin
            cycle();
            chk3("rstp.run", ((j % 6) >= 1) && ((j % 6) <= 3), (j % 6) == 1, 1'b1, 1'b0, 4'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
